// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: register bus and PHY byte-stream signals of the UART controller
interface uart_ctrl_if;
    logic       reg_en;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_rvalid;
    logic       irq;
    logic [7:0] phy_tx_data;
    logic       phy_tx_valid;
    logic       phy_tx_ready;
    logic [7:0] phy_rx_data;
    logic       phy_rx_ready;

    modport master (
        output reg_en, reg_we, reg_addr, reg_wdata, phy_tx_ready, phy_rx_data, phy_rx_ready,
        input  reg_rdata, reg_rvalid, irq, phy_tx_data, phy_tx_valid
    );

    modport slave (
        input  reg_en, reg_we, reg_addr, reg_wdata, phy_tx_ready, phy_rx_data, phy_rx_ready,
        output reg_rdata, reg_rvalid, irq, phy_tx_data, phy_tx_valid
    );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: register-mapped TX/RX byte FIFOs between a CPU bus and a UART PHY
module uart_ctrl #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_ctrl_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t ONE = ptr_t'(1);

    logic [7:0] tx_mem_q [FIFO_DEPTH];
    logic [7:0] tx_mem_d [FIFO_DEPTH];
    logic [7:0] rx_mem_q [FIFO_DEPTH];
    logic [7:0] rx_mem_d [FIFO_DEPTH];
    ptr_t       tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    ptr_t       rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic       rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
    logic [1:0] irq_en_q, irq_en_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d, irq_q, irq_d;

    logic       rd, wr, clr;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] status;

    assign rd       = bus.reg_en & ~bus.reg_we;
    assign wr       = bus.reg_en & bus.reg_we;
    assign clr      = wr & (bus.reg_addr == 2'd3);
    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    // Fullness is judged on the pre-cycle pointers, so a popping full TX FIFO still refuses the write.
    assign tx_push  = wr & (bus.reg_addr == 2'd0) & ~tx_full;
    assign tx_pop   = ~tx_empty & bus.phy_tx_ready;
    assign rx_pop   = rd & (bus.reg_addr == 2'd0) & ~rx_empty;
    // A full RX FIFO still accepts a byte when a DATA read frees the head slot in the same cycle.
    assign rx_push  = bus.phy_rx_ready & (~rx_full | rx_pop);
    assign status   = {2'b00, tx_empty & bus.phy_tx_ready, tx_ovf_q, rx_ovr_q, tx_empty, tx_full, ~rx_empty};

    assign bus.phy_tx_data  = tx_mem_q[tx_rp_q[AW-1:0]];
    assign bus.phy_tx_valid = ~tx_empty;
    assign bus.reg_rdata    = rdata_q;
    assign bus.reg_rvalid   = rvalid_q;
    assign bus.irq          = irq_q;

    // Next-state for FIFO storage, pointers, sticky flags, read data and interrupt.
    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push) tx_mem_d[tx_wp_q[AW-1:0]] = bus.reg_wdata;
        if (rx_push) rx_mem_d[rx_wp_q[AW-1:0]] = bus.phy_rx_data;
        tx_wp_d  = tx_push ? tx_wp_q + ONE : tx_wp_q;
        tx_rp_d  = tx_pop  ? tx_rp_q + ONE : tx_rp_q;
        rx_wp_d  = rx_push ? rx_wp_q + ONE : rx_wp_q;
        rx_rp_d  = rx_pop  ? rx_rp_q + ONE : rx_rp_q;
        tx_ovf_d = (wr & (bus.reg_addr == 2'd0) & tx_full) | (tx_ovf_q & ~(clr & bus.reg_wdata[1]));
        rx_ovr_d = (bus.phy_rx_ready & rx_full & ~rx_pop) | (rx_ovr_q & ~(clr & bus.reg_wdata[0]));
        irq_en_d = (wr & (bus.reg_addr == 2'd2)) ? bus.reg_wdata[1:0] : irq_en_q;
        rvalid_d = rd;
        rdata_d  = !rd                     ? rdata_q :
                   (bus.reg_addr == 2'd0)  ? (rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[AW-1:0]]) :
                   (bus.reg_addr == 2'd1)  ? status :
                   (bus.reg_addr == 2'd2)  ? {6'b0, irq_en_q} : 8'h00;
        irq_d    = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty) | rx_ovr_q | tx_ovf_q;
    end

    // FIFO storage needs no reset; emptiness comes from the pointers.
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovr_q <= 1'b0;
            irq_en_q <= 2'b00;
            rvalid_q <= 1'b0;
            rdata_q  <= 8'h00;
            irq_q    <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovr_q <= rx_ovr_d;
            irq_en_q <= irq_en_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed and random checks of uart_ctrl against a queue-based model
module tb_uart_ctrl;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic txr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_rx_ovr, m_tx_ovf;
    logic [1:0] m_irq_en;
    logic [7:0] e_rdata;
    logic       e_rvalid, e_irq;

    uart_ctrl_if bus();

    uart_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_rx_ovr = 1'b0;
        m_tx_ovf = 1'b0;
        m_irq_en = 2'b00;
        e_rdata  = 8'h00;
        e_rvalid = 1'b0;
        e_irq    = 1'b0;
    endtask

    function automatic logic [7:0] m_status();
        return {2'b00, logic'(tx_q.size() == 0 && txr), m_tx_ovf, m_rx_ovr,
                logic'(tx_q.size() == 0), logic'(tx_q.size() == DEPTH), logic'(rx_q.size() != 0)};
    endfunction

    task automatic check_outputs();
        chk("tx_valid", {7'b0, bus.phy_tx_valid}, {7'b0, logic'(tx_q.size() != 0)});
        if (tx_q.size() != 0) chk("tx_data", bus.phy_tx_data, tx_q[0]);
        chk("rvalid", {7'b0, bus.reg_rvalid}, {7'b0, e_rvalid});
        chk("rdata", bus.reg_rdata, e_rdata);
        chk("irq", {7'b0, bus.irq}, {7'b0, e_irq});
    endtask

    // One clock cycle: drive inputs, advance the model on pre-edge state, then compare.
    task automatic cyc(input logic en, input logic we, input logic [1:0] a, input logic [7:0] wd,
                       input logic rxv, input logic [7:0] rxd);
        logic rd, wr, tx_full, rx_pop;
        bus.reg_en = en; bus.reg_we = we; bus.reg_addr = a; bus.reg_wdata = wd;
        bus.phy_tx_ready = txr; bus.phy_rx_ready = rxv; bus.phy_rx_data = rxd;
        rd = en & ~we;
        wr = en & we;
        e_irq = (m_irq_en[0] && rx_q.size() != 0) || (m_irq_en[1] && tx_q.size() == 0) || m_rx_ovr || m_tx_ovf;
        e_rvalid = rd;
        if (rd) e_rdata = (a == 0) ? ((rx_q.size() != 0) ? rx_q[0] : 8'h00) :
                          (a == 1) ? m_status() : (a == 2) ? {6'b0, m_irq_en} : 8'h00;
        tx_full = tx_q.size() == DEPTH;
        rx_pop  = rd && a == 0 && rx_q.size() != 0;
        if (tx_q.size() != 0 && txr) void'(tx_q.pop_front());
        if (wr && a == 0 && !tx_full) tx_q.push_back(wd);
        m_tx_ovf = (wr && a == 0 && tx_full) || (m_tx_ovf && !(wr && a == 3 && wd[1]));
        if (rxv && rx_q.size() == DEPTH && !rx_pop) m_rx_ovr = 1'b1;
        else if (wr && a == 3 && wd[0]) m_rx_ovr = 1'b0;
        if (rx_pop) void'(rx_q.pop_front());
        if (rxv && rx_q.size() < DEPTH) rx_q.push_back(rxd);
        if (wr && a == 2) m_irq_en = wd[1:0];
        @(posedge clk);
        #1;
        check_outputs();
        bus.reg_en = 1'b0;
        bus.phy_rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        cyc(1, 1, a, d, 0, 0);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cyc(1, 0, a, 0, 0, 0);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        cyc(0, 0, 0, 0, 1, d);
    endtask

    initial begin
        bus.reg_en = 0; bus.reg_we = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
        bus.phy_tx_ready = 0; bus.phy_rx_ready = 0; bus.phy_rx_data = 0;
        model_reset();
        #12;
        chk("rst_tx_valid", {7'b0, bus.phy_tx_valid}, 8'h00);
        chk("rst_rvalid", {7'b0, bus.reg_rvalid}, 8'h00);
        chk("rst_rdata", bus.reg_rdata, 8'h00);
        chk("rst_irq", {7'b0, bus.irq}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two TX bytes streamed to a ready PHY
        txr = 1'b1;
        wr_reg(0, 8'h41);
        chk("tx_first", bus.phy_tx_data, 8'h41);
        wr_reg(0, 8'h42);
        chk("tx_second", bus.phy_tx_data, 8'h42);
        idle(1);
        rd_reg(1);
        chk("tx_done_status", bus.reg_rdata, 8'h24);

        // TX overflow with a stalled PHY, then drain
        txr = 1'b0;
        for (int i = 0; i <= 16; i++) wr_reg(0, 8'(i));
        rd_reg(1);
        chk("tx_full_status", bus.reg_rdata, 8'h12);
        txr = 1'b1;
        idle(17);
        wr_reg(3, 8'h02);

        // Single RX byte read back, then empty read
        rx_byte(8'h55);
        rd_reg(0);
        chk("rx_read", bus.reg_rdata, 8'h55);
        rd_reg(0);
        chk("rx_empty_read", bus.reg_rdata, 8'h00);
        rd_reg(1);
        chk("rx_nonempty_bit", {7'b0, bus.reg_rdata[0]}, 8'h00);

        // RX overrun, clear, and full drain
        for (int i = 0; i < 16; i++) rx_byte(8'($urandom_range(0, 255)));
        rx_byte(8'hAA);
        idle(1);
        chk("ovr_irq", {7'b0, bus.irq}, 8'h01);
        wr_reg(3, 8'h01);
        rd_reg(1);
        chk("ovr_cleared", {7'b0, bus.reg_rdata[3]}, 8'h00);
        for (int i = 0; i < 16; i++) rd_reg(0);

        // Full RX with simultaneous read and push
        for (int i = 0; i < 16; i++) rx_byte(8'(i + 8'h60));
        cyc(1, 0, 0, 0, 1, 8'h77);
        chk("full_pop_head", bus.reg_rdata, 8'h60);
        rd_reg(1);
        chk("full_pop_no_ovr", {7'b0, bus.reg_rdata[3]}, 8'h00);
        for (int i = 0; i < 16; i++) rd_reg(0);
        chk("full_pop_last", bus.reg_rdata, 8'h77);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            txr = 1'($urandom_range(0, 2) != 0);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
        end

        // Reset with both FIFOs partly filled
        idle(20);
        rd_reg(0);
        for (int i = 0; i < 20; i++) rd_reg(0);
        wr_reg(3, 8'h03);
        wr_reg(2, 8'h03);
        txr = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 8'(i + 8'hC0), 1, 8'(i + 8'hD0));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_tx_valid", {7'b0, bus.phy_tx_valid}, 8'h00);
        chk("mid_rst_irq", {7'b0, bus.irq}, 8'h00);
        chk("mid_rst_rvalid", {7'b0, bus.reg_rvalid}, 8'h00);
        chk("mid_rst_rdata", bus.reg_rdata, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b1;
        txr = 1'b1;
        rd_reg(1);
        chk("post_rst_status", bus.reg_rdata, 8'h24);
        rd_reg(0);
        chk("post_rst_rx_empty", bus.reg_rdata, 8'h00);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
